// File: rtl/div_seq_pkg.sv
// Shared constants for the sequential divider: datapath width, FSM encodings
// and the divide-by-zero quotient.
package div_seq_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_RUN  = 2'd1;
  localparam logic [1:0] DIV_FIN  = 2'd2;

  localparam logic [XLEN-1:0] DIV0_Q = '1;

endpackage

// File: rtl/div_seq_if.sv
// Request/response bundle between the EX stage and the sequential divider.
interface div_seq_if
  import div_seq_pkg::*;
#(
  parameter int unsigned W = XLEN
);

  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         busy;
  logic         done;
  logic [W-1:0] z_q;
  logic [W-1:0] z_r;
  logic         dz;

  modport master (
    output start, x, y,
    input  busy, done, z_q, z_r, dz
  );

  modport slave (
    input  start, x, y,
    output busy, done, z_q, z_r, dz
  );

endinterface

// File: rtl/div_seq_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_seq_step
  import div_seq_pkg::*;
#(
  parameter int unsigned W = XLEN
) (
  input  logic [W-1:0] i_rem,
  input  logic         i_dvd_msb,
  input  logic [W-1:0] i_dvs,
  output logic [W-1:0] o_rem_c,
  output logic         o_q_bit_c
);

  logic [W:0] w_sh;
  logic [W:0] w_diff;

  // Compare and subtract at full W+1 width; the result is always < divisor,
  // so narrowing back to W bits afterwards loses nothing.
  assign w_sh      = {i_rem, i_dvd_msb};
  assign w_diff    = w_sh - {1'b0, i_dvs};
  assign o_q_bit_c = (w_sh >= {1'b0, i_dvs});
  assign o_rem_c   = o_q_bit_c ? W'(w_diff) : W'(w_sh);

endmodule

// File: rtl/div_seq.sv
// Iterative restoring divider, one quotient bit per clock; busy stalls the
// pipeline while iterating and done pulses for one cycle with the results.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned W      = XLEN,
  parameter bit          SIGNED = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  s_if
);

  localparam int unsigned CW = $clog2(W);

  logic [1:0]    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  logic [W-1:0]  r_dvd,   w_dvd_nxt;
  logic [W-1:0]  r_dvs,   w_dvs_nxt;
  logic [W-1:0]  r_rem,   w_rem_nxt;
  logic          r_neg_q, w_neg_q_nxt;
  logic          r_neg_r, w_neg_r_nxt;
  logic          r_busy,  w_busy_nxt;
  logic          r_done,  w_done_nxt;
  logic [W-1:0]  r_zq,    w_zq_nxt;
  logic [W-1:0]  r_zr,    w_zr_nxt;
  logic          r_dz,    w_dz_nxt;

  logic          w_accept;
  logic          w_x_neg;
  logic          w_y_neg;
  logic [W-1:0]  w_x_abs;
  logic [W-1:0]  w_y_abs;
  logic [W-1:0]  w_rem_step;
  logic          w_q_bit;
  logic [W-1:0]  w_dvd_step;
  logic [W-1:0]  w_zq_fix;
  logic [W-1:0]  w_zr_fix;

  assign w_accept = s_if.start && (r_state != DIV_RUN);
  assign w_x_neg  = SIGNED && s_if.x[W-1];
  assign w_y_neg  = SIGNED && s_if.y[W-1];
  assign w_x_abs  = w_x_neg ? (~s_if.x + W'(1)) : s_if.x;
  assign w_y_abs  = w_y_neg ? (~s_if.y + W'(1)) : s_if.y;

  div_seq_step #(.W(W)) u_step (
    .i_rem     (r_rem),
    .i_dvd_msb (r_dvd[W-1]),
    .i_dvs     (r_dvs),
    .o_rem_c   (w_rem_step),
    .o_q_bit_c (w_q_bit)
  );

  // Quotient bits fill the dividend register from the bottom as it drains out the top.
  assign w_dvd_step = {r_dvd[W-2:0], w_q_bit};
  assign w_zq_fix   = r_neg_q ? (~w_dvd_step + W'(1)) : w_dvd_step;
  assign w_zr_fix   = r_neg_r ? (~w_rem_step + W'(1)) : w_rem_step;

  // Next-state, datapath and output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dvd_nxt   = r_dvd;
    w_dvs_nxt   = r_dvs;
    w_rem_nxt   = r_rem;
    w_neg_q_nxt = r_neg_q;
    w_neg_r_nxt = r_neg_r;
    w_zq_nxt    = r_zq;
    w_zr_nxt    = r_zr;
    w_dz_nxt    = r_dz;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;

    case (r_state)
      DIV_RUN: begin
        w_rem_nxt = w_rem_step;
        w_dvd_nxt = w_dvd_step;
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(W - 1)) begin
          w_state_nxt = DIV_FIN;
          w_zq_nxt    = w_zq_fix;
          w_zr_nxt    = w_zr_fix;
          w_dz_nxt    = 1'b0;
        end
      end
      DIV_IDLE, DIV_FIN: w_state_nxt = DIV_IDLE;
      default:           w_state_nxt = DIV_IDLE;
    endcase

    if (w_accept) begin
      if (s_if.y == '0) begin
        w_state_nxt = DIV_FIN;
        w_zq_nxt    = {W{1'b1}};
        w_zr_nxt    = s_if.x;
        w_dz_nxt    = 1'b1;
      end else begin
        w_state_nxt = DIV_RUN;
        w_cnt_nxt   = '0;
        w_dvd_nxt   = w_x_abs;
        w_dvs_nxt   = w_y_abs;
        w_rem_nxt   = '0;
        w_neg_q_nxt = w_x_neg ^ w_y_neg;
        w_neg_r_nxt = w_x_neg;
      end
    end

    w_busy_nxt = (w_state_nxt == DIV_RUN);
    w_done_nxt = (w_state_nxt == DIV_FIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_zq    <= '0;
      r_zr    <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dvd   <= w_dvd_nxt;
      r_dvs   <= w_dvs_nxt;
      r_rem   <= w_rem_nxt;
      r_neg_q <= w_neg_q_nxt;
      r_neg_r <= w_neg_r_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_zq    <= w_zq_nxt;
      r_zr    <= w_zr_nxt;
      r_dz    <= w_dz_nxt;
    end
  end

  assign s_if.busy = r_busy;
  assign s_if.done = r_done;
  assign s_if.z_q  = r_zq;
  assign s_if.z_r  = r_zr;
  assign s_if.dz   = r_dz;

endmodule

// File: tb/tb_div_seq.sv
// Drives an unsigned and a signed divider with identical stimulus and checks
// both against an arithmetic reference through a shared expectation queue.
module tb_div_seq;

  localparam int unsigned W   = 32;
  localparam int          LAT = int'(W) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  div_seq_if #(.W(W)) if_u ();
  div_seq_if #(.W(W)) if_s ();

  div_seq #(.W(W), .SIGNED(1'b0)) u_dut_u (.clk(clk), .rst(rst), .s_if(if_u));
  div_seq #(.W(W), .SIGNED(1'b1)) u_dut_s (.clk(clk), .rst(rst), .s_if(if_s));

  typedef struct {
    int           cyc;
    logic [W-1:0] q_u;
    logic [W-1:0] r_u;
    logic [W-1:0] q_s;
    logic [W-1:0] r_s;
    logic         dz;
  } exp_t;

  exp_t         q[$];
  exp_t         m_e;
  int           cyc     = 0;
  int           busy_lo = 0;
  int           busy_hi = -1;
  int           n_chk   = 0;
  int           n_pass  = 0;
  logic         eb;
  logic [W-1:0] l_qu = '0, l_ru = '0, l_qs = '0, l_rs = '0;
  logic         l_dz = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
  endfunction

  // Reference: plain integer division; 64-bit signed math makes MIN/-1 wrap naturally.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int c);
    exp_t   e;
    longint sx;
    longint sy;
    e.cyc = c;
    e.dz  = (y == '0);
    if (y == '0) begin
      e.q_u = '1; e.r_u = x; e.q_s = '1; e.r_s = x;
    end else begin
      e.q_u = x / y;
      e.r_u = x % y;
      sx    = longint'($signed(x));
      sy    = longint'($signed(y));
      e.q_s = W'(sx / sy);
      e.r_s = W'(sx % sy);
    end
    return e;
  endfunction

  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    if_u.start = s; if_u.x = x; if_u.y = y;
    if_s.start = s; if_s.x = x; if_s.y = y;
  endtask

  task automatic to_cycle(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #2;
    end
  endtask

  // One-cycle start pulse; the model decides whether the divider will take it.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    if (cyc > busy_hi) begin
      q.push_back(model(x, y, cyc + ((y == '0) ? 1 : LAT)));
      busy_lo = cyc + 1;
      busy_hi = (y == '0) ? cyc : cyc + int'(W);
    end
    drive(x, y, 1'b1);
    @(posedge clk);
    #2;
    drive($urandom, $urandom, 1'b0);
  endtask

  task automatic run(input logic [W-1:0] x, input logic [W-1:0] y, input int gap);
    issue(x, y);
    to_cycle(busy_hi + 1 + gap);
  endtask

  // Monitor: results exactly on the expected done cycle, everything held otherwise.
  always @(negedge clk) begin
    if (!rst) begin
      if (q.size() > 0 && cyc == q[0].cyc) begin
        m_e = q.pop_front();
        chk("flags_u", {if_u.done, if_u.busy, if_u.dz}, {1'b1, 1'b0, m_e.dz});
        chk("quot_u",  if_u.z_q, m_e.q_u);
        chk("rem_u",   if_u.z_r, m_e.r_u);
        chk("flags_s", {if_s.done, if_s.busy, if_s.dz}, {1'b1, 1'b0, m_e.dz});
        chk("quot_s",  if_s.z_q, m_e.q_s);
        chk("rem_s",   if_s.z_r, m_e.r_s);
        l_qu = m_e.q_u; l_ru = m_e.r_u; l_qs = m_e.q_s; l_rs = m_e.r_s; l_dz = m_e.dz;
      end else begin
        eb = (cyc >= busy_lo) && (cyc <= busy_hi);
        chk("hold_u", {if_u.done, if_u.busy, if_u.dz, if_u.z_q, if_u.z_r},
                      {1'b0, eb, l_dz, l_qu, l_ru});
        chk("hold_s", {if_s.done, if_s.busy, if_s.dz, if_s.z_q, if_s.z_r},
                      {1'b0, eb, l_dz, l_qs, l_rs});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           n;
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    int           gap;

    drive('0, '0, 1'b0);
    #1 rst = 1'b1;
    #2;
    chk("reset_u", {if_u.done, if_u.busy, if_u.dz, if_u.z_q, if_u.z_r}, '0);
    chk("reset_s", {if_s.done, if_s.busy, if_s.dz, if_s.z_q, if_s.z_r}, '0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    to_cycle(cyc + 2);

    run(32'd100, 32'd7, 0);
    run(32'hFFFF_FFFF, 32'd1, 1);
    run(32'd5, 32'd10, 0);
    run(32'd5, 32'd0, 0);
    run(32'd100, 32'd7, 2);
    run(32'hFFFF_FFF9, 32'd2, 0);
    run(32'd7, 32'hFFFF_FFFE, 0);
    run(32'h8000_0000, 32'hFFFF_FFFF, 3);
    run(32'h8000_0000, 32'd0, 0);
    run(32'd0, 32'd3, 0);

    // Start during RUN is ignored; start in the FIN cycle chains with no bubble.
    issue(32'd100, 32'd7);
    n = busy_lo - 1;
    to_cycle(n + 5);
    issue(32'd9, 32'd3);
    to_cycle(busy_hi + 1);
    run(32'd9, 32'd3, 2);

    // Reset in the middle of an operation.
    issue(32'd100, 32'd7);
    n = busy_lo - 1;
    to_cycle(n + 10);
    rst = 1'b1;
    q.delete();
    busy_lo = 0;
    busy_hi = -1;
    l_qu = '0; l_ru = '0; l_qs = '0; l_rs = '0; l_dz = 1'b0;
    #1;
    chk("midrst_u", {if_u.done, if_u.busy, if_u.dz, if_u.z_q, if_u.z_r}, '0);
    chk("midrst_s", {if_s.done, if_s.busy, if_s.dz, if_s.z_q, if_s.z_r}, '0);
    @(posedge clk);
    #2 rst = 1'b0;
    to_cycle(cyc + 40);
    run(32'd100, 32'd7, 1);

    for (int i = 0; i < 40; i++) begin
      rx = $urandom;
      if ($urandom_range(0, 7) == 0) rx = 32'h8000_0000;
      case ($urandom_range(0, 9))
        0:       ry = '0;
        1, 2, 3: ry = W'($urandom_range(1, 15));
        4:       ry = ~W'($urandom_range(0, 15));
        5:       ry = 32'hFFFF_FFFF;
        default: ry = $urandom;
      endcase
      gap = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        issue(rx, ry);
        to_cycle(cyc + $urandom_range(1, 20));
        issue($urandom, $urandom);
        to_cycle(busy_hi + 1 + gap);
      end else begin
        run(rx, ry, gap);
      end
    end

    to_cycle(busy_hi + 3);
    chk("drain", 96'(q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
